cpu_ctrl_fsm: RTL and testbench

Parametrised multi-cycle control unit for the CPU datapath, next generation of the fixed-latency fetch/decode/execute controller. It sequences fetch, decode, ALU, load/store, jump, branch and halt classes, and stretches memory phases to a configurable wait-state count plus a `mem_ready` handshake. An optional interrupt entry path is compiled in with a macro. It sits between the instruction decoder (class/wb/cond) and the PC, register file, flags, instruction register and memory port.

---
 rtl/cpu_ctrl_fsm.sv | 228 ++++++++++++++++++++++
 tb/tb_cpu_ctrl_fsm.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle fetch/decode/execute controller with configurable memory wait states.
// The optional interrupt entry path is enabled by defining CPU_CTRL_IRQ_EN.
module cpu_ctrl_fsm #(
  parameter int unsigned MEM_WAIT = 0,
  parameter int unsigned WAIT_W   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] iclass,
  input  logic       wb,
  input  logic       cond,
  input  logic       mem_ready,
  input  logic       resume,
  input  logic       irq,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       mem_req,
  output logic       mem_addr_sel,
  output logic       mem_we,
  output logic       ir_en,
  output logic       imm_sel,
  output logic       reg_wen,
  output logic [1:0] wb_sel,
  output logic       flags_en,
  output logic       halted,
  output logic       irq_ack,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC   = 4'd2,
    S_MEM    = 4'd3,
    S_JUMP   = 4'd4,
    S_BRANCH = 4'd5,
    S_HALT   = 4'd6,
    S_IRQ    = 4'd7
  } state_t;

  localparam logic [2:0] CL_ALU    = 3'd0;
  localparam logic [2:0] CL_ALUI   = 3'd1;
  localparam logic [2:0] CL_LOAD   = 3'd2;
  localparam logic [2:0] CL_STORE  = 3'd3;
  localparam logic [2:0] CL_JUMP   = 3'd4;
  localparam logic [2:0] CL_BRANCH = 3'd5;
  localparam logic [2:0] CL_HALT   = 3'd6;
  localparam logic [2:0] CL_NOP    = 3'd7;

  localparam logic [1:0] PC_INC    = 2'd0;
  localparam logic [1:0] PC_REG    = 2'd1;
  localparam logic [1:0] PC_BRANCH = 2'd2;
  localparam logic [1:0] PC_VECTOR = 2'd3;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_LINK = 2'd2;

  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(MEM_WAIT);

  if (MEM_WAIT > 15 || MEM_WAIT >= (1 << WAIT_W)) begin : g_bad_cfg
    $error("cpu_ctrl_fsm: MEM_WAIT out of range for WAIT_W");
  end

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] cnt_q;
  logic              cnt_zero;
  logic              access_done;
  logic              irq_take;
  state_t            exit_state;

  assign cnt_zero    = (cnt_q == '0);
  assign access_done = cnt_zero && mem_ready;

`ifdef CPU_CTRL_IRQ_EN
  logic irq_mask;

  // Masked from IRQ entry until a returning JUMP (wb=0) leaves its cycle.
  always_ff @(posedge clk) begin
    if (reset)                          irq_mask <= 1'b0;
    else if (state_q == S_IRQ)          irq_mask <= 1'b1;
    else if (state_q == S_JUMP && !wb)  irq_mask <= 1'b0;
  end

  assign irq_take = irq && !irq_mask;
`else
  logic unused_irq;
  assign unused_irq = irq;
  assign irq_take   = 1'b0;
`endif

  assign exit_state = irq_take ? S_IRQ : S_FETCH;

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // The counter restarts only on a real entry into a memory-phase state.
  always_ff @(posedge clk) begin
    if (reset)
      cnt_q <= WAIT_INIT;
    else if (state_d != state_q && (state_d == S_FETCH || state_d == S_MEM))
      cnt_q <= WAIT_INIT;
    else if (!cnt_zero)
      cnt_q <= cnt_q - WAIT_W'(1);
  end

  // NOTE: defaults first so every path assigns every output; no latches.
  always_comb begin
    state_d      = state_q;
    pc_en        = 1'b0;
    pc_src       = PC_INC;
    mem_req      = 1'b0;
    mem_addr_sel = 1'b0;
    mem_we       = 1'b0;
    ir_en        = 1'b0;
    imm_sel      = 1'b0;
    reg_wen      = 1'b0;
    wb_sel       = WB_ALU;
    flags_en     = 1'b0;
    halted       = 1'b0;
    irq_ack      = 1'b0;
    state_dbg    = state_q;

    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (access_done) begin
          ir_en   = 1'b1;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        imm_sel = (iclass == CL_ALUI);
        case (iclass)
          CL_ALU, CL_ALUI, CL_NOP: state_d = S_EXEC;
          CL_LOAD, CL_STORE:       state_d = S_MEM;
          CL_JUMP:                 state_d = S_JUMP;
          CL_BRANCH:               state_d = S_BRANCH;
          CL_HALT:                 state_d = S_HALT;
          default:                 state_d = S_FETCH;
        endcase
      end

      S_EXEC: begin
        pc_en = 1'b1;
        if (iclass == CL_ALU || iclass == CL_ALUI) begin
          imm_sel  = (iclass == CL_ALUI);
          reg_wen  = wb;
          flags_en = 1'b1;
        end
        state_d = exit_state;
      end

      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (iclass == CL_STORE);
        if (access_done) begin
          pc_en = 1'b1;
          if (iclass == CL_LOAD) begin
            reg_wen = 1'b1;
            wb_sel  = WB_MEM;
          end
          state_d = exit_state;
        end
      end

      S_JUMP: begin
        reg_wen = wb;
        wb_sel  = WB_LINK;
        pc_en   = 1'b1;
        pc_src  = PC_REG;
        state_d = exit_state;
      end

      S_BRANCH: begin
        pc_en   = 1'b1;
        pc_src  = cond ? PC_BRANCH : PC_INC;
        state_d = exit_state;
      end

      S_HALT: begin
        halted = 1'b1;
        // A pending interrupt beats resume and leaves the PC untouched.
        if (irq_take) begin
          state_d = S_IRQ;
        end else if (resume) begin
          pc_en   = 1'b1;
          state_d = S_FETCH;
        end
      end

      S_IRQ: begin
`ifdef CPU_CTRL_IRQ_EN
        reg_wen = 1'b1;
        wb_sel  = WB_LINK;
        pc_en   = 1'b1;
        pc_src  = PC_VECTOR;
        irq_ack = 1'b1;
`endif
        state_d = S_FETCH;
      end

      default: state_d = S_FETCH;
    endcase

    if (reset) begin
      pc_en        = 1'b0;
      pc_src       = PC_INC;
      mem_req      = 1'b0;
      mem_addr_sel = 1'b0;
      mem_we       = 1'b0;
      ir_en        = 1'b0;
      imm_sel      = 1'b0;
      reg_wen      = 1'b0;
      wb_sel       = WB_ALU;
      flags_en     = 1'b0;
      halted       = 1'b0;
      irq_ack      = 1'b0;
      state_dbg    = 4'd0;
    end
  end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Self-checking bench for cpu_ctrl_fsm: an instruction-level procedural model
// predicts every output on every cycle under randomized memory/irq stimulus.
module tb_cpu_ctrl_fsm;

  localparam int W = 2;
`ifdef CPU_CTRL_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] iclass;
  logic       wb, cond, mem_ready, resume, irq;
  logic       pc_en, mem_req, mem_addr_sel, mem_we, ir_en, imm_sel, reg_wen;
  logic       flags_en, halted, irq_ack;
  logic [1:0] pc_src, wb_sel;
  logic [3:0] state_dbg;

  always #5 clk = ~clk;

  cpu_ctrl_fsm #(.MEM_WAIT(W), .WAIT_W(4)) dut (
    .clk(clk), .reset(reset), .iclass(iclass), .wb(wb), .cond(cond),
    .mem_ready(mem_ready), .resume(resume), .irq(irq),
    .pc_en(pc_en), .pc_src(pc_src), .mem_req(mem_req), .mem_addr_sel(mem_addr_sel),
    .mem_we(mem_we), .ir_en(ir_en), .imm_sel(imm_sel), .reg_wen(reg_wen),
    .wb_sel(wb_sel), .flags_en(flags_en), .halted(halted), .irq_ack(irq_ack),
    .state_dbg(state_dbg)
  );

  typedef struct packed {
    logic       pc_en;
    logic [1:0] pc_src;
    logic       mem_req;
    logic       mem_addr_sel;
    logic       mem_we;
    logic       ir_en;
    logic       imm_sel;
    logic       reg_wen;
    logic [1:0] wb_sel;
    logic       flags_en;
    logic       halted;
    logic       irq_ack;
    logic [3:0] state;
  } vec_t;

  vec_t act_v;
  assign act_v = {pc_en, pc_src, mem_req, mem_addr_sel, mem_we, ir_en, imm_sel,
                  reg_wen, wb_sel, flags_en, halted, irq_ack, state_dbg};

  int ntests = 0;
  int nfail  = 0;
  int cyc    = 0;
  int n_we, n_pc_en, n_reg_wen, n_mem, n_halted, n_ack;
  int irq_mode;   // 0: never, 1: random, 2: always
  bit m_mask;     // model of the interrupt mask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic noise();
    resume = 1'($urandom_range(0, 1));
    case (irq_mode)
      0:       irq = 1'b0;
      1:       irq = ($urandom_range(0, 3) == 0);
      default: irq = 1'b1;
    endcase
  endtask

  // Inputs are set at the falling edge; outputs are compared 1 time unit later.
  task automatic tick(input vec_t e, input string name);
    #1;
    check(name, 32'(act_v), 32'(e));
    if (mem_we)              n_we++;
    if (pc_en)               n_pc_en++;
    if (reg_wen)             n_reg_wen++;
    if (state_dbg == 4'd3)   n_mem++;
    if (halted)              n_halted++;
    if (irq_ack)             n_ack++;
    cyc++;
    @(negedge clk);
  endtask

  task automatic irq_tick();
    vec_t e;
    e = '0;
    e.reg_wen = 1'b1; e.wb_sel = 2'd2; e.pc_en = 1'b1; e.pc_src = 2'd3;
    e.irq_ack = 1'b1; e.state = 4'd7;
    noise();
    tick(e, "irq_entry");
    m_mask = 1'b1;
  endtask

  task automatic exit_tick(input vec_t e, input string name, input bit clr_mask);
    bit take;
    noise();
    take = IRQ_EN && irq && !m_mask;
    if (clr_mask) m_mask = 1'b0;
    tick(e, name);
    if (take) irq_tick();
  endtask

  task automatic run_instr(input logic [2:0] cls, input logic wbv, input logic condv,
                           input int fstall, input int mstall, input int dwell,
                           input bit abort_mem, output int ncyc);
    vec_t e;
    int   c0;
    bit   take;
    c0 = cyc;
    n_we = 0; n_pc_en = 0; n_reg_wen = 0; n_mem = 0; n_halted = 0; n_ack = 0;
    iclass = 3'($urandom); wb = 1'($urandom); cond = 1'($urandom);

    e = '0; e.mem_req = 1'b1; e.state = 4'd0;
    for (int i = 0; i < W; i++) begin
      noise(); mem_ready = 1'($urandom_range(0, 1)); tick(e, "fetch_wait");
    end
    for (int i = 0; i < fstall; i++) begin
      noise(); mem_ready = 1'b0; tick(e, "fetch_stall");
    end
    noise(); mem_ready = 1'b1; e.ir_en = 1'b1; tick(e, "fetch_done");

    iclass = cls; wb = wbv; cond = condv;
    noise(); mem_ready = 1'($urandom_range(0, 1));
    e = '0; e.state = 4'd1; e.imm_sel = (cls == 3'd1);
    tick(e, "decode");

    e = '0;
    case (cls)
      3'd0, 3'd1, 3'd7: begin
        e.state = 4'd2; e.pc_en = 1'b1;
        if (cls != 3'd7) begin
          e.imm_sel = (cls == 3'd1); e.reg_wen = wbv; e.flags_en = 1'b1;
        end
        exit_tick(e, "exec", 1'b0);
      end
      3'd2, 3'd3: begin
        e.state = 4'd3; e.mem_req = 1'b1; e.mem_addr_sel = 1'b1; e.mem_we = (cls == 3'd3);
        for (int i = 0; i < W; i++) begin
          noise(); mem_ready = 1'($urandom_range(0, 1)); tick(e, "mem_wait");
          if (abort_mem && i == 0) begin
            reset = 1'b1; noise(); tick('0, "reset_in_mem");
            reset = 1'b0; m_mask = 1'b0;
            ncyc = cyc - c0;
            return;
          end
        end
        for (int i = 0; i < mstall; i++) begin
          noise(); mem_ready = 1'b0; tick(e, "mem_stall");
        end
        mem_ready = 1'b1; e.pc_en = 1'b1;
        if (cls == 3'd2) begin e.reg_wen = 1'b1; e.wb_sel = 2'd1; end
        exit_tick(e, "mem_done", 1'b0);
      end
      3'd4: begin
        e.state = 4'd4; e.reg_wen = wbv; e.wb_sel = 2'd2; e.pc_en = 1'b1; e.pc_src = 2'd1;
        exit_tick(e, "jump", !wbv);
      end
      3'd5: begin
        e.state = 4'd5; e.pc_en = 1'b1; e.pc_src = condv ? 2'd2 : 2'd0;
        exit_tick(e, "branch", 1'b0);
      end
      default: begin
        for (int i = 0; i <= dwell; i++) begin
          noise();
          resume = (i == dwell);
          take = IRQ_EN && irq && !m_mask;
          e = '0; e.state = 4'd6; e.halted = 1'b1;
          if (!take && resume) e.pc_en = 1'b1;
          tick(e, "halt");
          if (take) begin
            irq_tick();
            break;
          end
        end
        resume = 1'b0;
      end
    endcase
    ncyc = cyc - c0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; iclass = '0; wb = 1'b0; cond = 1'b0; mem_ready = 1'b0;
    resume = 1'b0; irq = 1'b0; irq_mode = 1; m_mask = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      noise(); mem_ready = 1'($urandom_range(0, 1)); iclass = 3'($urandom);
      tick('0, "reset_state");
    end
    reset = 1'b0;

    // Directed cases; literals below are for MEM_WAIT=2 with no irq.
    irq_mode = 0;
    run_instr(3'd0, 1'b1, 1'b0, 0, 0, 0, 1'b0, n);
    check("alu_cycles", 32'(n), 32'd5);
    check("alu_reg_wen_pulses", 32'(n_reg_wen), 32'd1);
    run_instr(3'd2, 1'b0, 1'b0, 0, 1, 0, 1'b0, n);
    check("load_mem_cycles", 32'(n_mem), 32'd4);
    check("load_reg_wen_pulses", 32'(n_reg_wen), 32'd1);
    run_instr(3'd3, 1'b1, 1'b0, 0, 0, 0, 1'b0, n);
    check("store_we_cycles", 32'(n_we), 32'd3);
    check("store_reg_wen", 32'(n_reg_wen), 32'd0);
    run_instr(3'd5, 1'b0, 1'b0, 0, 0, 0, 1'b0, n);
    run_instr(3'd5, 1'b0, 1'b1, 0, 0, 0, 1'b0, n);
    run_instr(3'd4, 1'b1, 1'b0, 0, 0, 0, 1'b0, n);
    check("jump_reg_wen_pulses", 32'(n_reg_wen), 32'd1);
    run_instr(3'd6, 1'b0, 1'b0, 0, 0, 5, 1'b0, n);
    check("halt_pc_en_pulses", 32'(n_pc_en), 32'd1);
    check("halt_cycles", 32'(n_halted), 32'd6);
    run_instr(3'd3, 1'b0, 1'b0, 0, 0, 0, 1'b1, n);
    run_instr(3'd7, 1'b0, 1'b0, 1, 0, 0, 1'b0, n);
    check("nop_after_reset_cycles", 32'(n), 32'd6);

`ifdef CPU_CTRL_IRQ_EN
    irq_mode = 2;
    run_instr(3'd0, 1'b1, 1'b0, 0, 0, 0, 1'b0, n);
    check("irq_first_ack", 32'(n_ack), 32'd1);
    run_instr(3'd0, 1'b1, 1'b0, 0, 0, 0, 1'b0, n);
    check("irq_masked_ack", 32'(n_ack), 32'd0);
    run_instr(3'd4, 1'b0, 1'b0, 0, 0, 0, 1'b0, n);
    check("irq_return_ack", 32'(n_ack), 32'd0);
    run_instr(3'd0, 1'b1, 1'b0, 0, 0, 0, 1'b0, n);
    check("irq_after_return_ack", 32'(n_ack), 32'd1);
`endif

    irq_mode = 1;
    for (int k = 0; k < 300; k++) begin
      run_instr(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 3),
                ($urandom_range(0, 49) == 0), n);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
